ram_reader: RTL and testbench

Sequential read-out engine for the latch-based RAM. It accepts a (start address, length) request, drives the RAM address with active-low output enable, waits a fixed settle time for the asynchronous latch array, captures each word, and streams the words out over a valid/ready handshake. It is the read side that pairs with the existing write and latch path. It sits between the RAM array and any consumer such as a CPU fetch path, a debug dump, or a testbench monitor.

---
 rtl/ram_reader_pkg.sv | 26 ++
 rtl/ram_reader_if.sv | 38 +++
 rtl/ram_reader_settle_timer.sv | 37 +++
 rtl/ram_reader.sv | 98 +++++++++
 tb/tb_ram_reader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared definitions for the RAM read-out engine.
//   - default address/data widths, shared with the RAM model
//   - FSM state encoding (IDLE / SETTLE / OUT)
//   - helper to size the settle counter
package ram_reader_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    // Width of a counter that must reach settle-1; never narrower than one bit.
    function automatic int cnt_width(input int settle);
        if (settle > 1) begin
            return $clog2(settle);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ram_reader_if.sv
// ram_reader_if: bus bundle between the read-out engine and its environment.
//   request : req_valid/req_ready/req_addr/req_len
//   RAM     : ram_addr/ram_oebar (to RAM), ram_data (from RAM, asynchronous)
//   stream  : out_valid/out_ready/out_data/out_last
//   status  : busy
// Modport master is the engine side; modport slave is the requester, RAM and
// consumer side.
interface ram_reader_if
    import ram_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W:0]   req_len;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_oebar;
    logic [DATA_W-1:0] ram_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;

    modport master (
        input  req_valid, req_addr, req_len, ram_data, out_ready,
        output req_ready, ram_addr, ram_oebar, out_valid, out_data, out_last, busy
    );

    modport slave (
        output req_valid, req_addr, req_len, ram_data, out_ready,
        input  req_ready, ram_addr, ram_oebar, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/ram_reader_settle_timer.sv
// ram_reader_settle_timer: up-counter that measures how long the RAM address
// has been held. It sits at zero while en is low and counts one per edge
// while en is high; done flags the cycle whose edge completes the settle time.
//   clk, rstbar : clock, asynchronous active-low reset
//   en          : count enable (engine is in SETTLE)
//   done        : count has reached SETTLE-1 while enabled
module ram_reader_settle_timer
    import ram_reader_pkg::*;
#(
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic clk,
    input  logic rstbar,
    input  logic en,
    output logic done
);

    localparam int              CNT_W = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] count_r;

    // Settle counter: cleared whenever the engine is not settling, so every
    // SETTLE entry starts from zero without an explicit load.
    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            count_r <= {CNT_W{1'b0}};
        end else if (!en) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign done = en && (count_r == LAST);

endmodule

// File: rtl/ram_reader.sv
// ram_reader: sequential read-out engine for the latch-based RAM.
// Takes a (start address, length) request, drives the RAM address with the
// active-low output enable asserted, waits SETTLE cycles for the asynchronous
// latch array, captures the word and offers it on a valid/ready stream.
// Addresses wrap modulo 2^ADDR_W; a zero-length request is a no-op.
//   clk, rstbar : clock, asynchronous active-low reset
//   bus         : ram_reader_if master (request, RAM, stream, busy)
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic         clk,
    input  logic         rstbar,
    ram_reader_if.master bus
);

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    state_e            state_r;
    logic [ADDR_W:0]   remaining_r;
    logic              settle_done_s;
    logic [DATA_W-1:0] cap_data_s;

    assign cap_data_s    = bus.ram_data;
    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.busy      = (state_r != ST_IDLE);

    ram_reader_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rstbar (rstbar),
        .en     (state_r == ST_SETTLE),
        .done   (settle_done_s)
    );

    // Read-out FSM with all bus outputs registered.
    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            state_r       <= ST_IDLE;
            remaining_r   <= {(ADDR_W+1){1'b0}};
            bus.ram_addr  <= {ADDR_W{1'b0}};
            bus.ram_oebar <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= {DATA_W{1'b0}};
            bus.out_last  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Zero-length requests are consumed without touching the RAM.
                    if (bus.req_valid && (bus.req_len != {(ADDR_W+1){1'b0}})) begin
                        bus.ram_addr  <= bus.req_addr;
                        bus.ram_oebar <= 1'b0;
                        remaining_r   <= bus.req_len;
                        state_r       <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done_s) begin
                        bus.out_data  <= cap_data_s;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= (remaining_r == REM_ONE);
                        state_r       <= ST_OUT;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_OUT: begin
                    // Captured word is held here; ram_data is not sampled.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (remaining_r == REM_ONE) begin
                            bus.ram_oebar <= 1'b1;
                            state_r       <= ST_IDLE;
                        end else begin
                            bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
                            remaining_r  <= remaining_r - REM_ONE;
                            state_r      <= ST_SETTLE;
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    bus.ram_oebar <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: self-checking bench for ram_reader (ADDR_W=4, DATA_W=8,
// SETTLE=2). Requests push their expected words (computed from a plain RAM
// array and modulo-16 address arithmetic) into a queue; a monitor on the
// falling edge compares every presented word against the queue head and pops
// on handshake. Directed sections add cycle-exact timing and reset checks.
module tb_ram_reader;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] addr;
    } exp_t;

    logic       clk;
    logic       rstbar;
    logic [7:0] mem [16];
    logic       glitch;
    logic       rand_ready;
    exp_t       sbq [$];
    int         n_vec;
    int         n_err;

    ram_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_reader #(.ADDR_W(4), .DATA_W(8), .SETTLE(2)) dut (
        .clk    (clk),
        .rstbar (rstbar),
        .bus    (bus)
    );

    // Asynchronous RAM model; glitch inverts the data to expose late sampling.
    assign bus.ram_data = glitch ? ~mem[bus.ram_addr] : mem[bus.ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random consumer back-pressure while enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compare every presented word against the queue head.
    always @(negedge clk) begin
        if (rstbar) begin
            chk("oebar_vs_busy", {31'd0, bus.ram_oebar}, {31'd0, !bus.busy});
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got data %0h with no word expected", bus.out_data);
                end else begin
                    chk("word_data", {24'd0, bus.out_data}, {24'd0, sbq[0].data});
                    chk("word_last", {31'd0, bus.out_last}, {31'd0, sbq[0].last});
                    chk("word_addr", {28'd0, bus.ram_addr}, {28'd0, sbq[0].addr});
                    if (bus.out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [3:0] a, input logic [4:0] len);
        int         c;
        logic [3:0] idx;
        exp_t       e;
        c = 0;
        while (!bus.req_ready && c < 400) begin
            tick();
            c++;
        end
        chk("req_ready_timeout", {31'd0, (c >= 400)}, 32'd0);
        for (int i = 0; i < int'(len); i++) begin
            idx    = a + 4'(i);
            e.data = mem[idx];
            e.last = (i == int'(len) - 1);
            e.addr = idx;
            sbq.push_back(e);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'($urandom);
        bus.req_len   = 5'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((bus.busy || sbq.size() != 0) && c < 400) begin
            tick();
            c++;
        end
        chk({name, "_timeout"}, {31'd0, (c >= 400)}, 32'd0);
    endtask

    initial begin
        int c;
        n_vec         = 0;
        n_err         = 0;
        glitch        = 1'b0;
        rand_ready    = 1'b0;
        rstbar        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'd0;
        bus.req_len   = 5'd0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) mem[j] = 8'($urandom);

        // Reset values.
        tick();
        tick();
        chk("rst_ram_addr",  {28'd0, bus.ram_addr},  32'd0);
        chk("rst_oebar",     {31'd0, bus.ram_oebar}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, bus.out_data},  32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        rstbar = 1'b1;
        tick();

        // Two-word read with exact timing.
        mem[3] = 8'hA5;
        mem[4] = 8'h5A;
        issue(4'd3, 5'd2);
        chk("t1_e0_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t1_e0_addr",  {28'd0, bus.ram_addr},  32'd3);
        chk("t1_e0_oebar", {31'd0, bus.ram_oebar}, 32'd0);
        chk("t1_e0_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk("t1_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("t1_e2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_e2_data",  {24'd0, bus.out_data},  32'hA5);
        chk("t1_e2_last",  {31'd0, bus.out_last},  32'd0);
        tick();
        chk("t1_e3_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("t1_e4_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("t1_e5_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_e5_data",  {24'd0, bus.out_data},  32'h5A);
        chk("t1_e5_last",  {31'd0, bus.out_last},  32'd1);
        tick();
        chk("t1_e6_oebar", {31'd0, bus.ram_oebar}, 32'd1);
        chk("t1_e6_busy",  {31'd0, bus.busy},      32'd0);
        chk("t1_e6_ready", {31'd0, bus.req_ready}, 32'd1);
        wait_idle("t1");

        // Address wrap F, 0, 1.
        issue(4'hF, 5'd3);
        wait_idle("wrap");

        // Back-pressure with toggling RAM data.
        bus.out_ready = 1'b0;
        issue(4'd2, 5'd2);
        c = 0;
        while (!bus.out_valid && c < 50) begin
            tick();
            c++;
        end
        chk("bp_valid_timeout", {31'd0, (c >= 50)}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            glitch = ~glitch;
            tick();
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_data",  {24'd0, bus.out_data},  {24'd0, mem[2]});
            chk("bp_hold_addr",  {28'd0, bus.ram_addr},  32'd2);
        end
        glitch        = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle("bp");

        // Zero-length request.
        issue(4'd5, 5'd0);
        for (int k = 0; k < 4; k++) begin
            chk("zl_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("zl_oebar", {31'd0, bus.ram_oebar}, 32'd1);
            chk("zl_ready", {31'd0, bus.req_ready}, 32'd1);
            tick();
        end

        // Full sweep from 7.
        issue(4'd7, 5'd16);
        wait_idle("sweep");

        // Randomized requests with random back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            issue(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)));
            if (r % 5 == 4) begin
                wait_idle("rand");
                for (int j = 0; j < 16; j++) mem[j] = 8'($urandom);
            end
        end
        wait_idle("rand_end");
        rand_ready = 1'b0;
        tick();
        bus.out_ready = 1'b1;

        // Reset during SETTLE of the second word.
        mem[5] = 8'h3C;
        issue(4'd5, 5'd3);
        c = 0;
        while (!bus.out_valid && c < 50) begin
            tick();
            c++;
        end
        chk("mr_valid_timeout", {31'd0, (c >= 50)}, 32'd0);
        tick();
        chk("mr_in_settle_addr", {28'd0, bus.ram_addr}, 32'd6);
        #2;
        rstbar = 1'b0;
        #1;
        sbq.delete();
        chk("mr_ram_addr",  {28'd0, bus.ram_addr},  32'd0);
        chk("mr_oebar",     {31'd0, bus.ram_oebar}, 32'd1);
        chk("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mr_out_data",  {24'd0, bus.out_data},  32'd0);
        chk("mr_out_last",  {31'd0, bus.out_last},  32'd0);
        chk("mr_busy",      {31'd0, bus.busy},      32'd0);
        tick();
        tick();
        rstbar = 1'b1;
        tick();
        issue(4'd0, 5'd1);
        wait_idle("post_rst");
        chk("post_rst_oebar", {31'd0, bus.ram_oebar}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
